// File: rtl/fsm_flujo_umbrales.sv
// fsm_flujo_umbrales: global flow-control FSM with per-FIFO pause hysteresis.
// The FSM supervises NUM_FIFOS FIFOs. While it is in INIT it loads the low and
// high thresholds every cycle. In IDLE and ACTIVE each FIFO raises pause when its
// count reaches the high threshold, and drops pause when its count falls to the
// low threshold. A fifo_err pulse sends the FSM into ERROR, and ERROR is left
// only through reset.
// Optional: define FSM_WATCHDOG_EN to add a watchdog. It forces ERROR when pause
// has been held in ACTIVE for WDOG_CYCLES consecutive cycles.
module fsm_flujo_umbrales #(
  parameter int NUM_FIFOS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [CNT_W-1:0]           umbral_bajo,
  input  logic [CNT_W-1:0]           umbral_alto,
  input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
  input  logic [NUM_FIFOS-1:0]       empty_fifos,
  input  logic [NUM_FIFOS-1:0]       fifo_err,
  output logic [4:0]                 estado_actual,
  output logic [4:0]                 sig_estado,
  output logic [CNT_W-1:0]           bajo_out,
  output logic [CNT_W-1:0]           alto_out,
  output logic [NUM_FIFOS-1:0]       pause,
  output logic                       active_out,
  output logic                       idle_out,
  output logic                       error_out,
  output logic                       cfg_err
);

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Reject parameter sets the comparators or the watchdog cannot represent
  if (CNT_W < $clog2(FIFO_DEPTH + 1) || WDOG_CYCLES < 2) begin : g_bad_param
    $error("fsm_flujo_umbrales: CNT_W too narrow for FIFO_DEPTH or WDOG_CYCLES < 2");
  end

  logic [4:0]           state_q, state_d;
  logic [CNT_W-1:0]     bajo_q, alto_q;
  logic [NUM_FIFOS-1:0] pause_q, pause_d, hyst;
  logic                 active_q, idle_q, error_q, cfg_err_q;
  logic                 cfg_ok, all_empty, any_err, wdog_hit;

  // The thresholds being loaded are checked directly, so INIT can be left on
  // the same edge that captures a valid pair.
  assign cfg_ok    = (umbral_bajo < umbral_alto) && (umbral_alto <= DEPTH_C);
  assign all_empty = &empty_fifos;
  assign any_err   = |fifo_err;

  // Per-lane hysteresis. Set has priority, but it cannot conflict with clear
  // because the thresholds are valid (bajo < alto).
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    assign cnt     = fifo_count[i*CNT_W +: CNT_W];
    assign hyst[i] = (cnt >= alto_q) ? 1'b1 :
                     (cnt <= bajo_q) ? 1'b0 : pause_q[i];
  end

`ifdef FSM_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;

  assign wdog_hit = (state_q == S_ACTIVE) && (|pause_q) &&
                    (wd_q == WD_W'(WDOG_CYCLES - 1));

  // The counter advances only while ACTIVE holds pause and stays ACTIVE
  always_comb begin
    wd_d = '0;
    if (state_q == S_ACTIVE && (|pause_q) && state_d == S_ACTIVE)
      wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state logic. Priority order: error, then init, then empty-based moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (any_err)              state_d = S_ERROR;
        else if (!init && cfg_ok) state_d = all_empty ? S_IDLE : S_ACTIVE;
      end
      S_IDLE, S_ACTIVE: begin
        if (any_err || wdog_hit)  state_d = S_ERROR;
        else if (init)            state_d = S_INIT;
        else                      state_d = all_empty ? S_IDLE : S_ACTIVE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  // Pause update rules:
  // - forced to all ones when entering or staying in ERROR;
  // - cleared on entry to INIT;
  // - updated by hysteresis only while running (IDLE or ACTIVE).
  always_comb begin
    pause_d = pause_q;
    if (state_d == S_ERROR)                              pause_d = '1;
    else if (state_d == S_INIT)                          pause_d = '0;
    else if (state_q == S_IDLE || state_q == S_ACTIVE)   pause_d = hyst;
  end

  // State, thresholds, pause and flag registers. The flags are decoded from
  // the next state, so they line up with estado_actual.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      bajo_q    <= '0;
      alto_q    <= '0;
      pause_q   <= '0;
      active_q  <= 1'b0;
      idle_q    <= 1'b0;
      error_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      active_q <= (state_d == S_ACTIVE);
      idle_q   <= (state_d == S_IDLE);
      error_q  <= (state_d == S_ERROR);
      if (state_q == S_INIT) begin
        bajo_q    <= umbral_bajo;
        alto_q    <= umbral_alto;
        cfg_err_q <= !cfg_ok;
      end
    end
  end

  assign estado_actual = state_q;
  assign sig_estado    = state_d;
  assign bajo_out      = bajo_q;
  assign alto_out      = alto_q;
  assign pause         = pause_q;
  assign active_out    = active_q;
  assign idle_out      = idle_q;
  assign error_out     = error_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_fsm_flujo_umbrales.sv
// Bench for fsm_flujo_umbrales: directed scenarios followed by random traffic,
// all compared against a behavioural model of states, thresholds and pause bits.
module tb_fsm_flujo_umbrales;
  localparam int NF = 8, CW = 5, DEPTH = 16, WD = 64;

  logic              clk = 1'b0;
  logic              reset, init;
  logic [CW-1:0]     ub, ua;
  logic [NF*CW-1:0]  fcnt;
  logic [NF-1:0]     empty, ferr;
  logic [4:0]        estado_actual, sig_estado;
  logic [CW-1:0]     bajo_out, alto_out;
  logic [NF-1:0]     pause;
  logic              active_out, idle_out, error_out, cfg_err;

  fsm_flujo_umbrales #(.NUM_FIFOS(NF), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_bajo(ub), .umbral_alto(ua),
    .fifo_count(fcnt), .empty_fifos(empty), .fifo_err(ferr),
    .estado_actual(estado_actual), .sig_estado(sig_estado),
    .bajo_out(bajo_out), .alto_out(alto_out), .pause(pause),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: state index 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
  int       m_s = 0, m_bajo = 0, m_alto = 0, m_wd = 0;
  bit [NF-1:0] m_pause = '0;
  bit       m_cfg = 0;
  int       cnts[NF];

  function automatic int nxt();
    bit ok, all_e, hit;
    ok    = (int'(ub) < int'(ua)) && (int'(ua) <= DEPTH);
    all_e = (empty == {NF{1'b1}});
    hit   = 0;
`ifdef FSM_WATCHDOG_EN
    hit = (m_s == 3) && (m_pause != 0) && (m_wd == WD - 1);
`endif
    if (m_s == 0) return 1;
    if (m_s == 4) return 4;
    if (ferr != 0 || hit) return 4;
    if (m_s == 1) return (!init && ok) ? (all_e ? 2 : 3) : 1;
    if (init) return 1;
    return all_e ? 2 : 3;
  endfunction

  task automatic model_edge();
    int n;
    n = nxt();
    if (m_s == 3 && m_pause != 0 && n == 3) m_wd++;
    else m_wd = 0;
    if (n == 4) m_pause = '1;
    else if (n == 1) m_pause = '0;
    else if (m_s == 2 || m_s == 3)
      for (int i = 0; i < NF; i++) begin
        if (cnts[i] >= m_alto) m_pause[i] = 1'b1;
        else if (cnts[i] <= m_bajo) m_pause[i] = 1'b0;
      end
    if (m_s == 1) begin
      m_bajo = int'(ub);
      m_alto = int'(ua);
      m_cfg  = !((int'(ub) < int'(ua)) && (int'(ua) <= DEPTH));
    end
    m_s = n;
  endtask

  task automatic model_reset();
    m_s = 0; m_bajo = 0; m_alto = 0; m_wd = 0; m_pause = '0; m_cfg = 0;
  endtask

  task automatic check_outs();
    chk("estado", 32'(estado_actual), 32'(1 << m_s));
    chk("pause", 32'(pause), 32'(m_pause));
    chk("bajo", 32'(bajo_out), 32'(m_bajo));
    chk("alto", 32'(alto_out), 32'(m_alto));
    chk("active", 32'(active_out), 32'(m_s == 3));
    chk("idle", 32'(idle_out), 32'(m_s == 2));
    chk("error", 32'(error_out), 32'(m_s == 4));
    chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
  endtask

  // Called at a falling edge with the inputs already set. It checks
  // sig_estado, takes one rising edge, checks the registered outputs and
  // returns at the next falling edge.
  task automatic step();
    for (int i = 0; i < NF; i++) fcnt[i*CW +: CW] = CW'(cnts[i]);
    #1;
    chk("sig_estado", 32'(sig_estado), 32'(1 << nxt()));
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int pseq[6]  = '{5, 12, 8, 4, 3, 2};
  int pexp[6]  = '{0, 1, 1, 1, 0, 0};

  initial begin
    reset = 1'b1; init = 1'b0; ub = '0; ua = '0; fcnt = '0; empty = '1; ferr = '0;
    for (int i = 0; i < NF; i++) cnts[i] = 0;
    @(negedge clk);
    do_reset();

    // Bring-up: RESET -> INIT -> IDLE
    init = 1'b1; ub = 5'd3; ua = 5'd12; empty = 8'hFF;
    step(); step();
    init = 1'b0;
    step();
    chk("boot_idle", 32'(idle_out), 32'd1);
    chk("boot_bajo", 32'(bajo_out), 32'd3);
    chk("boot_alto", 32'(alto_out), 32'd12);

    // Invalid thresholds hold INIT
    init = 1'b1; step();
    init = 1'b0; ub = 5'd12; ua = 5'd3; step();
    chk("bad_cfg_state", 32'(estado_actual), 32'h02);
    chk("bad_cfg_err", 32'(cfg_err), 32'd1);
    ub = 5'd3; ua = 5'd12; step();
    chk("good_cfg_err", 32'(cfg_err), 32'd0);
    chk("good_cfg_idle", 32'(idle_out), 32'd1);

    // ACTIVE and pause[0] hysteresis
    empty = 8'hFE; step();
    chk("to_active", 32'(active_out), 32'd1);
    for (int k = 0; k < 6; k++) begin
      cnts[0] = pseq[k];
      step();
      chk("hyst_p0", 32'(pause[0]), 32'(pexp[k]));
    end

    // fifo_err takes priority over init
    ferr = 8'h10; init = 1'b1; step();
    chk("err_state", 32'(estado_actual), 32'h10);
    chk("err_pause", 32'(pause), 32'hFF);
    ferr = '0; init = 1'b0; empty = 8'hFF;
    for (int k = 0; k < 3; k++) step();
    chk("err_sticky", 32'(error_out), 32'd1);
    do_reset();
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_err", 32'(error_out), 32'd0);

    // Reset while ACTIVE with pause = 03
    init = 1'b1; ub = 5'd3; ua = 5'd12; step(); step();
    init = 1'b0; empty = 8'hFE; step();
    cnts[0] = 14; cnts[1] = 14; step();
    chk("pause03", 32'(pause), 32'h03);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("abort_state", 32'(estado_actual), 32'h01);
    chk("abort_pause", 32'(pause), 32'd0);
    chk("abort_thr", 32'({bajo_out, alto_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NF; i++) cnts[i] = 0;

`ifdef FSM_WATCHDOG_EN
    init = 1'b1; step(); step();
    init = 1'b0; empty = 8'hFE; step();
    cnts[0] = 14;
    for (int k = 0; k < 30; k++) step();
    cnts[0] = 2; step();
    cnts[0] = 14;
    for (int k = 0; k < 40; k++) step();
    chk("wd_no_err", 32'(error_out), 32'd0);
    for (int k = 0; k < 70; k++) step();
    chk("wd_err", 32'(error_out), 32'd1);
    cnts[0] = 0;
    do_reset();
`endif

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        ferr = ($urandom_range(0, 299) == 0) ? NF'(1 << $urandom_range(0, NF-1)) : '0;
        init = ($urandom_range(0, 24) == 0) ? 1'b1 : (init && ($urandom_range(0, 2) != 0));
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            ub = CW'($urandom_range(0, 31));
            ua = CW'($urandom_range(0, 31));
          end else begin
            ub = CW'($urandom_range(0, DEPTH - 2));
            ua = CW'($urandom_range(int'(ub) + 1, DEPTH));
          end
        end
        empty = ($urandom_range(0, 9) < 4) ? '1 : NF'($urandom);
        for (int i = 0; i < NF; i++)
          if ($urandom_range(0, 2) == 0)
            cnts[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31))
                                                   : int'($urandom_range(0, DEPTH));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
